alu_issue_stage: RTL



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_control_decode.sv | 36 +++
 rtl/alu_issue_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, aluOp/funct encodings and the issue record
// carried from the issue stage to the ALU.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_IMM_W  = 16;
    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SGT = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'd8;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_AND   = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE = 2'd2;
    localparam logic [1:0] ALUOP_SUB   = 2'd3;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_SRA = 6'h03;
    localparam logic [5:0] FUNCT_SGT = 6'h2C;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] input1;
        logic [ALU_DATA_W-1:0] input2;
        logic [ALU_CTRL_W-1:0] aluControlOut;
        logic [4:0]            shumt;
        logic                  illegalOp;
    } aluIssue_t;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational aluOp/funct -> ALU control code map; flags undefined R-type functs.
module alu_control_decode
    import alu_pkg::*;
(
    input  logic [1:0]            aluOp_i,
    input  logic [5:0]            funct_i,
    output logic [ALU_CTRL_W-1:0] ctrl_o,
    output logic                  illegal_o
);

    always_comb begin
        ctrl_o    = ALU_ADD;
        illegal_o = 1'b0;
        case (aluOp_i)
            ALUOP_ADD: ctrl_o = ALU_ADD;
            ALUOP_AND: ctrl_o = ALU_AND;
            ALUOP_SUB: ctrl_o = ALU_SUB;
            default: begin
                case (funct_i)
                    FUNCT_ADD: ctrl_o = ALU_ADD;
                    FUNCT_SUB: ctrl_o = ALU_SUB;
                    FUNCT_AND: ctrl_o = ALU_AND;
                    FUNCT_OR:  ctrl_o = ALU_OR;
                    FUNCT_SLL: ctrl_o = ALU_SLL;
                    FUNCT_SRL: ctrl_o = ALU_SRL;
                    FUNCT_SRA: ctrl_o = ALU_SRA;
                    FUNCT_SGT: ctrl_o = ALU_SGT;
                    FUNCT_SLT: ctrl_o = ALU_SLT;
                    // Unknown functs still issue as an add so the pipe keeps moving.
                    default:   illegal_o = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the op, picks operand 2 and buffers results in a 2-entry skid.
// Optional ALU_ISSUE_PERF_EN adds issueCount/stallCount performance counters.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int IMM_W  = ALU_IMM_W,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [1:0]        aluOp,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rsData,
    input  logic [DATA_W-1:0] rtData,
    input  logic [IMM_W-1:0]  imm,
    input  logic              useImm,
    input  logic [4:0]        shamt,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [CTRL_W-1:0] aluControlOut,
    output logic [4:0]        shumt,
    output logic              illegalOp
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       issueCount,
    output logic [31:0]       stallCount
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t    state_q;
    aluIssue_t out_q;
    aluIssue_t skid_q;
    logic      outValid_q;
    logic      inReady_q;

    aluIssue_t             issue_d;
    logic [CTRL_W-1:0]     dec_ctrl;
    logic                  dec_illegal;
    logic [DATA_W-1:0]     imm_ext;
    logic                  in_fire;
    logic                  out_fire;

    alu_control_decode u_decode (
        .aluOp_i   (aluOp),
        .funct_i   (funct),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // andi zero-extends; every other immediate user sign-extends.
    assign imm_ext = (aluOp == ALUOP_AND) ? {{(DATA_W-IMM_W){1'b0}}, imm}
                                          : {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        issue_d               = '0;
        issue_d.input1        = rsData;
        issue_d.input2        = useImm ? imm_ext : rtData;
        issue_d.aluControlOut = dec_ctrl;
        issue_d.shumt         = shamt;
        issue_d.illegalOp     = dec_illegal;
    end

    assign in_fire  = inValid && inReady_q;
    assign out_fire = outValid_q && outReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        out_q      <= issue_d;
                        outValid_q <= 1'b1;
                        state_q    <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        out_q <= issue_d;
                    end else if (in_fire) begin
                        skid_q    <= issue_d;
                        inReady_q <= 1'b0;
                        state_q   <= S_FULL;
                    end else if (out_fire) begin
                        outValid_q <= 1'b0;
                        state_q    <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // inReady is low here, so no new op can arrive this cycle.
                    if (outReady) begin
                        out_q     <= skid_q;
                        inReady_q <= 1'b1;
                        state_q   <= S_ONE;
                    end
                end
                default: begin
                    state_q    <= S_EMPTY;
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                end
            endcase
        end
    end

    assign inReady       = inReady_q;
    assign outValid      = outValid_q;
    assign input1        = out_q.input1;
    assign input2        = out_q.input2;
    assign aluControlOut = out_q.aluControlOut;
    assign shumt         = out_q.shumt;
    assign illegalOp     = out_q.illegalOp;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issueCount_q;
    logic [31:0] stallCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issueCount_q <= '0;
            stallCount_q <= '0;
        end else begin
            if (out_fire) begin
                issueCount_q <= issueCount_q + 32'd1;
            end
            if (outValid_q && !outReady) begin
                stallCount_q <= stallCount_q + 32'd1;
            end
        end
    end

    assign issueCount = issueCount_q;
    assign stallCount = stallCount_q;
`endif

endmodule
